// File: rtl/lc3b_types.sv
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b memory-system types and L2 arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_L1_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam logic c_GRANT_ICACHE = 1'b0;
   localparam logic c_GRANT_DCACHE = 1'b1;

   // Fair tie-break: on a collision the dcache wins only if icache was served last.
   function automatic logic arb_dcache_wins(input logic d_req,
                                            input logic i_req,
                                            input logic last_grant);
      return d_req && (!i_req || (last_grant == c_GRANT_ICACHE));
   endfunction

endpackage

`default_nettype wire

// File: rtl/l2_arbiter.sv
// ============================================================================
// Module      : l2_arbiter
// Description : Serialises icache/dcache line transactions onto one L2 port.
//               Optional fair arbitration: define ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_arbiter
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        reset,

   input  logic        icache_L2_read,
   input  lc3b_word    icache_L2_address,
   output lc3b_L1_line icache_L2_rdata,
   output logic        icache_L2_resp,

   input  logic        dcache_L2_read,
   input  logic        dcache_L2_write,
   input  lc3b_word    dcache_L2_address,
   input  lc3b_L1_line dcache_L2_wdata,
   output lc3b_L1_line dcache_L2_rdata,
   output logic        dcache_L2_resp,

   output logic        L2_read,
   output logic        L2_write,
   output lc3b_word    L2_address,
   output lc3b_L1_line L2_wdata,
   input  lc3b_L1_line L2_rdata,
   input  logic        L2_resp
);

   arb_state_t r_state;
   logic       w_i_req;
   logic       w_d_req;
   logic       w_d_wins;

   assign w_i_req = icache_L2_read;
   assign w_d_req = dcache_L2_read | dcache_L2_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_grant;

   assign w_d_wins = arb_dcache_wins(w_d_req, w_i_req, r_last_grant);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= c_GRANT_ICACHE;
      end else if (L2_resp && (r_state == SERVE_I)) begin
         r_last_grant <= c_GRANT_ICACHE;
      end else if (L2_resp && (r_state == SERVE_D)) begin
         r_last_grant <= c_GRANT_DCACHE;
      end
   end
`else
   assign w_d_wins = w_d_req;
`endif

   // The grant is only ever re-decided from IDLE, so it is stable until L2_resp.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_d_wins) begin
                  r_state <= SERVE_D;
               end else if (w_i_req) begin
                  r_state <= SERVE_I;
               end
            end
            SERVE_I: begin
               if (L2_resp) begin
                  r_state <= RELEASE;
               end
            end
            SERVE_D: begin
               if (L2_resp) begin
                  r_state <= RELEASE;
               end
            end
            RELEASE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign icache_L2_rdata = L2_rdata;
   assign dcache_L2_rdata = L2_rdata;

   always_comb begin
      L2_read        = 1'b0;
      L2_write       = 1'b0;
      L2_address     = '0;
      L2_wdata       = '0;
      icache_L2_resp = 1'b0;
      dcache_L2_resp = 1'b0;
      case (r_state)
         SERVE_I: begin
            L2_read        = 1'b1;
            L2_address     = icache_L2_address;
            icache_L2_resp = L2_resp;
         end
         SERVE_D: begin
            // A simultaneous read+write strobe forwards only the write-back.
            L2_read        = dcache_L2_read & ~dcache_L2_write;
            L2_write       = dcache_L2_write;
            L2_address     = dcache_L2_address;
            L2_wdata       = dcache_L2_wdata;
            dcache_L2_resp = L2_resp;
         end
         default: begin
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
// ============================================================================
// Module      : tb_l2_arbiter
// Description : Directed self-checking bench for l2_arbiter (both arbitration modes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_arbiter;
   import lc3b_types::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        icache_L2_read;
   lc3b_word    icache_L2_address;
   lc3b_L1_line icache_L2_rdata;
   logic        icache_L2_resp;
   logic        dcache_L2_read;
   logic        dcache_L2_write;
   lc3b_word    dcache_L2_address;
   lc3b_L1_line dcache_L2_wdata;
   lc3b_L1_line dcache_L2_rdata;
   logic        dcache_L2_resp;
   logic        L2_read;
   logic        L2_write;
   lc3b_word    L2_address;
   lc3b_L1_line L2_wdata;
   lc3b_L1_line L2_rdata;
   logic        L2_resp;

   int checks = 0;
   int errors = 0;

   l2_arbiter u_dut (
      .clk               (clk),
      .reset             (reset),
      .icache_L2_read    (icache_L2_read),
      .icache_L2_address (icache_L2_address),
      .icache_L2_rdata   (icache_L2_rdata),
      .icache_L2_resp    (icache_L2_resp),
      .dcache_L2_read    (dcache_L2_read),
      .dcache_L2_write   (dcache_L2_write),
      .dcache_L2_address (dcache_L2_address),
      .dcache_L2_wdata   (dcache_L2_wdata),
      .dcache_L2_rdata   (dcache_L2_rdata),
      .dcache_L2_resp    (dcache_L2_resp),
      .L2_read           (L2_read),
      .L2_write          (L2_write),
      .L2_address        (L2_address),
      .L2_wdata          (L2_wdata),
      .L2_rdata          (L2_rdata),
      .L2_resp           (L2_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered in an IDLE cycle with requests already driven; leaves in the next IDLE cycle.
   task automatic run_txn(input string tag, input bit exp_d, input logic exp_rd,
                          input logic exp_wr, input logic [15:0] exp_addr,
                          input logic [127:0] exp_wdata, input int lat,
                          input logic [127:0] rdata);
      #1;
      check({tag, "_idle_rd"}, L2_read, 1'b0);
      check({tag, "_idle_wr"}, L2_write, 1'b0);
      step();
      for (int k = 1; k <= lat; k++) begin
         L2_resp  = (k == lat);
         L2_rdata = (k == lat) ? rdata : '0;
         #1;
         check({tag, "_rd"}, L2_read, exp_rd);
         check({tag, "_wr"}, L2_write, exp_wr);
         check({tag, "_addr"}, L2_address, exp_addr);
         if (exp_d) check({tag, "_wdata"}, L2_wdata, exp_wdata);
         check({tag, "_iresp"}, icache_L2_resp, (k == lat) && !exp_d);
         check({tag, "_dresp"}, dcache_L2_resp, (k == lat) && exp_d);
         if (k == lat) begin
            check({tag, "_irdata"}, icache_L2_rdata, rdata);
            check({tag, "_drdata"}, dcache_L2_rdata, rdata);
         end
         step();
      end
      // RELEASE: served requester drops; a spurious L2_resp here must not leak out.
      L2_resp  = 1'b1;
      L2_rdata = '0;
      if (exp_d) begin
         dcache_L2_read  = 1'b0;
         dcache_L2_write = 1'b0;
      end else begin
         icache_L2_read = 1'b0;
      end
      #1;
      check({tag, "_rel_rd"}, L2_read, 1'b0);
      check({tag, "_rel_wr"}, L2_write, 1'b0);
      check({tag, "_rel_iresp"}, icache_L2_resp, 1'b0);
      check({tag, "_rel_dresp"}, dcache_L2_resp, 1'b0);
      step();
      L2_resp = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit exp_seq [3];
      logic [127:0] pat_a5;
      logic [127:0] pat_5a;
      pat_a5 = {16{8'hA5}};
      pat_5a = {16{8'h5A}};

      reset             = 1'b1;
      icache_L2_read    = 1'b0;
      icache_L2_address = '0;
      dcache_L2_read    = 1'b0;
      dcache_L2_write   = 1'b0;
      dcache_L2_address = '0;
      dcache_L2_wdata   = '0;
      L2_rdata          = '0;
      L2_resp           = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state, with a stray L2_resp in IDLE
      L2_resp = 1'b1;
      #1;
      check("rst_rd", L2_read, 1'b0);
      check("rst_wr", L2_write, 1'b0);
      check("rst_addr", L2_address, 16'h0);
      check("rst_wdata", L2_wdata, 128'h0);
      check("rst_iresp", icache_L2_resp, 1'b0);
      check("rst_dresp", dcache_L2_resp, 1'b0);
      step();
      L2_resp = 1'b0;

      // icache fill alone, four serve cycles
      icache_L2_read    = 1'b1;
      icache_L2_address = 16'h1230;
      run_txn("ird", 1'b0, 1'b1, 1'b0, 16'h1230, '0, 4, 128'h0123456789ABCDEF_FEDCBA9876543210);

      // dcache write-back
      dcache_L2_write   = 1'b1;
      dcache_L2_address = 16'h4000;
      dcache_L2_wdata   = pat_a5;
      run_txn("dwr", 1'b1, 1'b0, 1'b1, 16'h4000, pat_a5, 2, 128'h0);

      // dcache read and write together: only the write is forwarded
      dcache_L2_read    = 1'b1;
      dcache_L2_write   = 1'b1;
      dcache_L2_address = 16'h4010;
      dcache_L2_wdata   = pat_5a;
      run_txn("drw", 1'b1, 1'b0, 1'b1, 16'h4010, pat_5a, 3, 128'h77);

      // dcache read alone
      dcache_L2_read    = 1'b1;
      dcache_L2_address = 16'h3000;
      run_txn("drd", 1'b1, 1'b1, 1'b0, 16'h3000, pat_5a, 1, 128'hBEEF);

      // Reset while serving icache
      icache_L2_read    = 1'b1;
      icache_L2_address = 16'h0500;
      #1;
      step();
      check("mrst_serve_rd", L2_read, 1'b1);
      reset = 1'b1;
      step();
      reset          = 1'b0;
      icache_L2_read = 1'b0;
      L2_resp        = 1'b1;
      L2_rdata       = 128'h55;
      #1;
      check("mrst_rd", L2_read, 1'b0);
      check("mrst_wr", L2_write, 1'b0);
      check("mrst_addr", L2_address, 16'h0);
      check("mrst_iresp", icache_L2_resp, 1'b0);
      check("mrst_dresp", dcache_L2_resp, 1'b0);
      step();
      check("mrst_late_iresp", icache_L2_resp, 1'b0);
      check("mrst_late_rd", L2_read, 1'b0);
      L2_resp = 1'b0;
      step();

      // Simultaneous requests from reset state: dcache first, then icache
      icache_L2_read    = 1'b1;
      icache_L2_address = 16'h0100;
      dcache_L2_read    = 1'b1;
      dcache_L2_address = 16'h2000;
      run_txn("both_d", 1'b1, 1'b1, 1'b0, 16'h2000, pat_5a, 2, 128'hD1);
      run_txn("both_i", 1'b0, 1'b1, 1'b0, 16'h0100, '0, 2, 128'h11);

      // Both re-request after every release (last grant is now icache)
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq = '{1'b1, 1'b0, 1'b1};
`else
      exp_seq = '{1'b1, 1'b1, 1'b1};
`endif
      for (int n = 0; n < 3; n++) begin
         icache_L2_read = 1'b1;
         dcache_L2_read = 1'b1;
         if (exp_seq[n])
            run_txn($sformatf("alt%0d_d", n), 1'b1, 1'b1, 1'b0, 16'h2000, pat_5a, 2, 128'hA0 + n);
         else
            run_txn($sformatf("alt%0d_i", n), 1'b0, 1'b1, 1'b0, 16'h0100, '0, 2, 128'hB0 + n);
      end
      icache_L2_read = 1'b0;
      dcache_L2_read = 1'b0;
      step();

      // L2 stalls 50 cycles with a competing dcache request
      icache_L2_read    = 1'b1;
      icache_L2_address = 16'h0ABC;
      #1;
      step();
      dcache_L2_read    = 1'b1;
      dcache_L2_address = 16'h2222;
      for (int k = 0; k < 50; k++) begin
         #1;
         check($sformatf("stall%0d_rd", k), L2_read, 1'b1);
         check($sformatf("stall%0d_addr", k), L2_address, 16'h0ABC);
         check($sformatf("stall%0d_dresp", k), dcache_L2_resp, 1'b0);
         step();
      end
      L2_resp  = 1'b1;
      L2_rdata = 128'hCAFE;
      #1;
      check("stall_iresp", icache_L2_resp, 1'b1);
      check("stall_dresp_end", dcache_L2_resp, 1'b0);
      step();
      L2_resp        = 1'b0;
      icache_L2_read = 1'b0;
      #1;
      check("stall_rel_rd", L2_read, 1'b0);
      step();
      run_txn("after_stall_d", 1'b1, 1'b1, 1'b0, 16'h2222, pat_5a, 2, 128'hF00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
